debug_hub: RTL and testbench

- Parametrised successor of the board debug block. Selects one of N_CH debug words for the seven-segment display, in manual, auto-scan or hold mode.
- Generates a divided display/CPU clock, plus a CPU clock-enable that free-runs or single-steps from a debounced push button.
- Sits between the CPU core's debug taps and the display driver on the FPGA top level.

---
 rtl/debug_pkg.sv | 27 ++
 rtl/debug_debounce.sv | 50 +++++
 rtl/debug_hub.sv | 127 ++++++++++++
 tb/tb_debug_hub.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and mode decoding for the board debug hub.
package debug_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  localparam int unsigned DEF_DIV_MAX    = 50000;
  localparam int unsigned DEF_SCAN_DWELL = 500;
  localparam int unsigned DEF_DEB_TICKS  = 4;

  typedef enum logic [1:0] {
    CH_MANUAL,
    CH_SCAN,
    CH_HOLD
  } ch_state_t;

  // Mode 2'b11 is reserved and behaves as manual.
  function automatic ch_state_t decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_SCAN: return CH_SCAN;
      MODE_HOLD: return CH_HOLD;
      default:   return CH_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/debug_debounce.sv
// Step-button conditioning: 2-flop synchroniser, tick-sampled debounce and
// a one-clk pulse on each accepted press.
module debug_debounce import debug_pkg::*; #(
  parameter int unsigned DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             armed;
  logic             sample;

  assign sample = sync[1];

  // Synchroniser resets to "pressed" and presses are only reported once a
  // released sample has been seen, so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sample_en) begin
        if (sample == level) begin
          cnt <= '0;
          if (!level) armed <= 1'b1;
        end else if (cnt == CNT_W'(DEB_TICKS - 1)) begin
          cnt   <= '0;
          level <= sample;
          rise  <= sample & armed;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debug_hub.sv
// Debug channel selector, display/CPU clock divider and CPU step control.
// Define DEBUG_HUB_BREAK_EN to add the channel-0 breakpoint (bp_en, bp_val, halted).
module debug_hub import debug_pkg::*; #(
  parameter  int unsigned N_CH       = 8,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned DIV_MAX    = DEF_DIV_MAX,
  parameter  int unsigned SCAN_DWELL = DEF_SCAN_DWELL,
  parameter  int unsigned DEB_TICKS  = DEF_DEB_TICKS,
  localparam int unsigned CH_W       = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] debug_data,
  input  logic [CH_W-1:0]        sel,
  input  logic [1:0]             mode,
  input  logic                   run,
  input  logic                   step_btn,
`ifdef DEBUG_HUB_BREAK_EN
  input  logic                   bp_en,
  input  logic [DATA_W-1:0]      bp_val,
  output logic                   halted,
`endif
  output logic                   div_tick,
  output logic                   div_clk,
  output logic                   cpu_clk_en,
  output logic [DATA_W-1:0]      disp_data,
  output logic [CH_W-1:0]        disp_ch,
  output logic [15:0]            step_cnt
);

  localparam int unsigned     DIV_W   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);
  localparam int unsigned     DWELL_W = (SCAN_DWELL < 2) ? 1 : $clog2(SCAN_DWELL + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [DIV_W-1:0]   div_cnt;
  ch_state_t          state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CH_W-1:0]    ch_d;
  logic [DATA_W-1:0]  data_d;
  logic               step_req;

  assign div_tick = (div_cnt == DIV_W'(DIV_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_clk  <= 1'b0;
      step_cnt <= '0;
    end else begin
      if (div_tick) begin
        div_cnt <= '0;
        div_clk <= ~div_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (cpu_clk_en) step_cnt <= step_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_MANUAL;
      dwell_q   <= '0;
      disp_ch   <= '0;
      disp_data <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      disp_ch   <= ch_d;
      disp_data <= data_d;
    end
  end

  // state_q holds the previous cycle's mode, so entry into scan is visible here.
  always_comb begin
    state_d = decode_mode(mode);
    dwell_d = dwell_q;
    ch_d    = disp_ch;
    case (state_d)
      CH_MANUAL: ch_d = (32'(sel) > N_CH - 1) ? LAST_CH : sel;
      CH_SCAN: begin
        if (state_q != CH_SCAN) begin
          dwell_d = '0;
        end else if (div_tick) begin
          if (dwell_q == DWELL_W'(SCAN_DWELL - 1)) begin
            dwell_d = '0;
            ch_d    = (disp_ch == LAST_CH) ? '0 : disp_ch + CH_W'(1);
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      end
      default: ;
    endcase
    data_d = (state_d == CH_HOLD) ? disp_data : debug_data[32'(ch_d)*DATA_W +: DATA_W];
  end

  debug_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .sample_en(div_tick),
    .btn      (step_btn),
    .rise     (step_req)
  );

`ifdef DEBUG_HUB_BREAK_EN
  logic bp_hit;

  assign bp_hit = run && bp_en && div_tick && (debug_data[DATA_W-1:0] == bp_val);

  always_comb begin
    if (halted || !run) cpu_clk_en = step_req;
    else if (bp_hit)    cpu_clk_en = 1'b0;
    else                cpu_clk_en = div_tick;
  end

  always_ff @(posedge clk) begin
    if (rst || !run || !bp_en) halted <= 1'b0;
    else if (bp_hit)           halted <= 1'b1;
  end
`else
  assign cpu_clk_en = run ? div_tick : step_req;
`endif

endmodule

// File: tb/tb_debug_hub.sv
// Scoreboard bench for debug_hub: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_debug_hub;

  localparam int unsigned N_CH   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH_W   = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   run;
  logic                   step_btn;
  logic [CH_W-1:0]        sel;
  logic [1:0]             mode;
  logic [N_CH*DATA_W-1:0] debug_data;
  logic [DATA_W-1:0]      ch [N_CH];
  logic                   div_tick, div_clk, cpu_clk_en;
  logic [DATA_W-1:0]      disp_data;
  logic [CH_W-1:0]        disp_ch;
  logic [15:0]            step_cnt;
`ifdef DEBUG_HUB_BREAK_EN
  logic                   bp_en;
  logic [DATA_W-1:0]      bp_val;
  logic                   halted;
`endif

  always #5 clk = ~clk;

  always_comb begin
    debug_data = '0;
    for (int k = 0; k < N_CH; k++) debug_data[k*DATA_W +: DATA_W] = ch[k];
  end

  debug_hub #(
    .N_CH(N_CH), .DATA_W(DATA_W), .DIV_MAX(3), .SCAN_DWELL(2), .DEB_TICKS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .debug_data(debug_data),
    .sel       (sel),
    .mode      (mode),
    .run       (run),
    .step_btn  (step_btn),
`ifdef DEBUG_HUB_BREAK_EN
    .bp_en     (bp_en),
    .bp_val    (bp_val),
    .halted    (halted),
`endif
    .div_tick  (div_tick),
    .div_clk   (div_clk),
    .cpu_clk_en(cpu_clk_en),
    .disp_data (disp_data),
    .disp_ch   (disp_ch),
    .step_cnt  (step_cnt)
  );

  typedef enum {W_DATA, W_CH, W_TICK, W_DCLK, W_PULSES, W_STEPS, W_HALTED} what_t;
  typedef struct {
    string       name;
    what_t       what;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pulses      = 0;
  logic en_prev     = 1'b0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (cpu_clk_en === 1'b1) pulses++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.what)
        W_DATA:   act = disp_data;
        W_CH:     act = 32'(disp_ch);
        W_TICK:   act = 32'(div_tick);
        W_DCLK:   act = 32'(div_clk);
        W_PULSES: act = 32'(pulses);
        W_STEPS:  act = 32'(step_cnt);
`ifdef DEBUG_HUB_BREAK_EN
        W_HALTED: act = 32'(halted);
`endif
        default:  act = 'x;
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input what_t w, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.what = w;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within budget, expected event", name);
  endtask

  // Channel 0 models a CPU register that advances by 4 per enabled clock.
  task automatic ramp_cycles(input int n);
    logic en_now;
    repeat (n) begin
      cyc(1);
      en_now = cpu_clk_en;
      if (en_prev) ch[0] = ch[0] + 32'd4;
      en_prev = en_now;
    end
  endtask

  task automatic count_ticks(input int want, input string name);
    int ticks;
    ticks = 0;
    for (int i = 0; i < 40 && ticks < want; i++) begin
      cyc(1);
      if (div_tick) ticks++;
    end
    if (ticks < want) timeout_fail(name);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_btn = 1'b0; sel = '0; mode = 2'b00;
    for (int k = 0; k < N_CH; k++) ch[k] = 32'h1000_0000 + 32'(k);
`ifdef DEBUG_HUB_BREAK_EN
    bp_en = 1'b0; bp_val = '0;
`endif
    cyc(3);
    expect_v("rst_data", W_DATA, 32'h0);
    expect_v("rst_ch", W_CH, 32'h0);
    expect_v("rst_tick", W_TICK, 32'h0);
    expect_v("rst_dclk", W_DCLK, 32'h0);
    expect_v("rst_steps", W_STEPS, 32'h0);
    expect_v("rst_pulses", W_PULSES, 32'h0);

    // Divider: cycle c after release has cnt == c mod 4.
    rst = 1'b0;
    expect_v("tick_c0", W_TICK, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      expect_v($sformatf("tick_c%0d", c), W_TICK, 32'((c % 4) == 3));
      expect_v($sformatf("dclk_c%0d", c), W_DCLK, 32'((c / 4) % 2));
    end

    // Manual selection and one-clk data latency.
    ch[5] = 32'hDEAD_BEEF; sel = 3'd5;
    cyc(1);
    expect_v("man_ch5", W_CH, 32'd5);
    expect_v("man_data5", W_DATA, 32'hDEAD_BEEF);
    ch[5] = 32'h1;
    cyc(1);
    expect_v("man_data5_upd", W_DATA, 32'h1);
    mode = 2'b11; sel = 3'd2; ch[2] = 32'hC2;
    cyc(1);
    expect_v("mode11_ch", W_CH, 32'd2);
    expect_v("mode11_data", W_DATA, 32'hC2);

    // Hold.
    mode = 2'b00; sel = 3'd3; ch[3] = 32'h1234;
    cyc(1);
    expect_v("hold_pre", W_DATA, 32'h1234);
    mode = 2'b10; ch[3] = 32'h5678; sel = 3'd6;
    cyc(1);
    expect_v("hold_data", W_DATA, 32'h1234);
    expect_v("hold_ch", W_CH, 32'd3);
    cyc(3);
    expect_v("hold_data_late", W_DATA, 32'h1234);
    mode = 2'b00; sel = 3'd3;
    cyc(1);
    expect_v("unhold_data", W_DATA, 32'h5678);

    // Auto-scan from channel 6, entered on a non-tick cycle.
    sel = 3'd6;
    cyc(1);
    expect_v("scan_start", W_CH, 32'd6);
    for (int i = 0; i < 8 && div_tick; i++) cyc(1);
    mode = 2'b01;
    count_ticks(2, "scan_first");
    expect_v("scan_before_adv", W_CH, 32'd6);
    cyc(1);
    expect_v("scan_ch7", W_CH, 32'd7);
    expect_v("scan_data7", W_DATA, 32'h1000_0007);
    count_ticks(2, "scan_second");
    expect_v("scan_before_wrap", W_CH, 32'd7);
    cyc(1);
    expect_v("scan_wrap_ch", W_CH, 32'd0);
    expect_v("scan_wrap_data", W_DATA, 32'h1000_0000);
    mode = 2'b00; sel = 3'd0;

    // Single-step: glitch, clean press, press held through reset.
    step_btn = 1'b1; cyc(8); step_btn = 1'b0; cyc(30);
    expect_v("glitch_pulses", W_PULSES, 32'd0);
    expect_v("glitch_steps", W_STEPS, 32'd0);
    step_btn = 1'b1; cyc(20); step_btn = 1'b0; cyc(40);
    expect_v("press_pulses", W_PULSES, 32'd1);
    expect_v("press_steps", W_STEPS, 32'd1);
    step_btn = 1'b1; cyc(4); rst = 1'b1; cyc(3);
    expect_v("rst2_steps", W_STEPS, 32'd0);
    rst = 1'b0; cyc(40);
    expect_v("held_pulses", W_PULSES, 32'd1);
    expect_v("held_steps", W_STEPS, 32'd0);
    step_btn = 1'b0; cyc(40);
    step_btn = 1'b1; cyc(20); step_btn = 1'b0; cyc(40);
    expect_v("repress_pulses", W_PULSES, 32'd2);
    expect_v("repress_steps", W_STEPS, 32'd1);

    // Free-run: any 8 consecutive cycles hold exactly two ticks.
    run = 1'b1; cyc(8);
    expect_v("run_steps", W_STEPS, 32'd3);
    run = 1'b0; cyc(2);
    expect_v("run_pulses", W_PULSES, 32'd4);

`ifdef DEBUG_HUB_BREAK_EN
    rst = 1'b1; run = 1'b1; bp_en = 1'b1; bp_val = 32'h40; ch[0] = 32'h30;
    cyc(3);
    rst = 1'b0; en_prev = 1'b0;
    for (int i = 0; i < 200 && halted !== 1'b1; i++) ramp_cycles(1);
    if (halted !== 1'b1) timeout_fail("bp_halt_wait");
    expect_v("bp_halted", W_HALTED, 32'd1);
    expect_v("bp_steps", W_STEPS, 32'd4);
    ramp_cycles(12);
    expect_v("bp_hold_steps", W_STEPS, 32'd4);
    step_btn = 1'b1; ramp_cycles(20); step_btn = 1'b0; ramp_cycles(40);
    expect_v("bp_step_steps", W_STEPS, 32'd5);
    expect_v("bp_step_halted", W_HALTED, 32'd1);
    run = 1'b0;
    cyc(1);
    expect_v("bp_clear", W_HALTED, 32'd0);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 time units, expected completion");
    $fatal(1);
  end

endmodule
